// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute stage and the sequential divider.
interface seq_divider_if #(parameter int XLEN = 32);
  logic            start;
  logic            is_signed;
  logic            is_rem;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, is_signed, is_rem, dividend, divisor,
                  input  busy, done, result);
  modport slave  (input  start, is_signed, is_rem, dividend, divisor,
                  output busy, done, result);
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Signed operation is built only when DIV_SIGNED_EN is defined; otherwise all ops are unsigned.
module seq_divider #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t          state_q, state_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_rem_q, is_rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] q_out, r_out;

`ifdef DIV_SIGNED_EN
  // -2^31 negates to itself, which is the correct magnitude read unsigned
  assign a_neg = bus.is_signed & bus.dividend[XLEN-1];
  assign b_neg = bus.is_signed & bus.divisor[XLEN-1];
  assign a_mag = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag = b_neg ? -bus.divisor  : bus.divisor;
  assign q_out = qneg_q ? -quo_q : quo_q;
  assign r_out = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  logic unused_bits;
  assign unused_bits = rem_q[XLEN];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_out = quo_q;
  assign r_out = rem_q[XLEN-1:0];
  logic unused_bits;
  assign unused_bits = rem_q[XLEN] ^ bus.is_signed ^ qneg_q ^ rneg_q;
`endif

  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] trial;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    done_d   = 1'b0;
    rem_sh   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    trial    = {1'b0, rem_sh} - {2'b00, dvs_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          is_rem_d = bus.is_rem;
          cnt_d    = '0;
          dvs_d    = b_mag;
          if (bus.divisor == '0) begin
            // Divide by zero: results are architecturally fixed, no sign fix-up
            quo_d   = '1;
            rem_d   = {1'b0, bus.dividend};
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = FINISH;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[XLEN+1]) begin
          rem_d = trial[XLEN:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = FINISH;
      end
      FINISH: begin
        result_d = is_rem_q ? r_out : q_out;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: results, latency, busy/done timing, ignore-start and reset abort.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  seq_divider_if #(.XLEN(32)) bus ();

  seq_divider #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where done is seen, so consecutive calls are back-to-back.
  task automatic do_op(input string tag, input bit sg, input bit rm,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int exp_lat, input int inj);
    int lat;
    bus.start = 1'b1; bus.is_signed = sg; bus.is_rem = rm;
    bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = 32'hDEAD_BEEF; bus.divisor = 32'h0000_0003;
    lat = 1;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    while (!bus.done && lat < 100) begin
      if (lat == inj) begin
        bus.start = 1'b1; bus.dividend = 32'd7; bus.divisor = 32'd7;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, bus.result, exp_r);
    chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int extra;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.is_rem = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst = 1'b0;

    do_op("divu_100_7", 0, 0, 32'd100, 32'd7, 32'd14, 34, 0);
    do_op("remu_100_7", 0, 1, 32'd100, 32'd7, 32'd2, 34, 0);
`ifdef DIV_SIGNED_EN
    do_op("div_m7_2",   1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    do_op("rem_m7_2",   1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    do_op("div_ovf",    1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
    do_op("rem_ovf",    1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
`else
    do_op("div_m7_2",   1, 0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, 0);
    do_op("rem_m7_2",   1, 1, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 34, 0);
    do_op("div_ovf",    1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
    do_op("rem_ovf",    1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
`endif
    do_op("divu_5_0",   0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 0);
    do_op("rem_m5_0",   1, 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2, 0);
    do_op("divu_max_1", 0, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0);

    // Result holds after the done pulse.
    repeat (3) @(negedge clk);
    chk("hold_done",   {31'd0, bus.done}, 32'd0);
    chk("hold_result", bus.result, 32'hFFFF_FFFF);

    // A start mid-operation must be ignored entirely.
    do_op("inj_1000_10", 0, 0, 32'd1000, 32'd10, 32'd100, 34, 10);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk("inj_extra_done", extra, 0);
    chk("inj_result",     bus.result, 32'd100);

    // Reset in the middle of an operation aborts it.
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.is_rem = 1'b0;
    bus.dividend = 32'd50; bus.divisor = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy",   {31'd0, bus.busy}, 32'd0);
    chk("abort_done",   {31'd0, bus.done}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("divu_9_3", 0, 0, 32'd9, 32'd3, 32'd3, 34, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
